// File: rtl/font_glyph_renderer.sv
// Character-cell glyph renderer: fetches each glyph row from a synchronous font ROM,
// resolves attributes and the fixed palette, and streams coloured pixel rows downstream.
module font_glyph_renderer #(
    parameter int CHAR_BITS            = 8,
    parameter int COLOR_NUMBERS_BITS   = 4,
    parameter int HEIGHT_PER_CHARACTER = 20,
    parameter int WIDTH_PER_CHARACTER  = 8,
    parameter int COLOR_CHANNEL_BITS   = 8,
    parameter int ROM_ADDR_BITS        = $clog2((2**CHAR_BITS)*HEIGHT_PER_CHARACTER),
    localparam int ROW_BITS            = $clog2(HEIGHT_PER_CHARACTER),
    localparam int PIX_BITS            = WIDTH_PER_CHARACTER*COLOR_CHANNEL_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          reqValid,
    output logic                          reqReady,
    input  logic [CHAR_BITS-1:0]          char,
    input  logic [COLOR_NUMBERS_BITS-1:0] foregroundColor,
    input  logic [COLOR_NUMBERS_BITS-1:0] backgroundColor,
    input  logic                          attrReverse,
    input  logic                          attrUnderline,
    input  logic                          attrBlink,
    input  logic                          blinkPhase,
    output logic [ROM_ADDR_BITS-1:0]      romAddress,
    input  logic [WIDTH_PER_CHARACTER-1:0] romData,
    output logic                          rowValid,
    input  logic                          rowReady,
    output logic [ROW_BITS-1:0]           rowIndex,
    output logic                          rowLast,
    output logic [PIX_BITS-1:0]           fontColorR,
    output logic [PIX_BITS-1:0]           fontColorG,
    output logic [PIX_BITS-1:0]           fontColorB
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT
    } state_t;

    localparam logic [COLOR_CHANNEL_BITS-1:0] CH_HALF = COLOR_CHANNEL_BITS'(1) << (COLOR_CHANNEL_BITS-1);

    state_t                         r_state;
    state_t                         w_nextState;
    logic [CHAR_BITS-1:0]           r_char;
    logic [COLOR_NUMBERS_BITS-1:0]  r_fg;
    logic [COLOR_NUMBERS_BITS-1:0]  r_bg;
    logic                           r_rev;
    logic                           r_ul;
    logic                           r_blink;
    logic [ROW_BITS-1:0]            r_row;

    logic [ROM_ADDR_BITS-1:0]       w_addrFirst;
    logic [ROM_ADDR_BITS-1:0]       w_addrNext;
    logic [WIDTH_PER_CHARACTER-1:0] w_bits;
    logic [COLOR_NUMBERS_BITS-1:0]  w_fgIdx;
    logic [COLOR_NUMBERS_BITS-1:0]  w_bgIdx;
    logic [COLOR_NUMBERS_BITS-1:0]  w_idx;
    logic [PIX_BITS-1:0]            w_pixR;
    logic [PIX_BITS-1:0]            w_pixG;
    logic [PIX_BITS-1:0]            w_pixB;

    function automatic logic [COLOR_CHANNEL_BITS-1:0] chanLevel(input logic on, input logic bright);
        if (!on)
            return '0;
        return bright ? {COLOR_CHANNEL_BITS{1'b1}} : CH_HALF;
    endfunction

    assign reqReady    = (r_state == S_IDLE);
    assign w_addrFirst = ROM_ADDR_BITS'(char) * ROM_ADDR_BITS'(HEIGHT_PER_CHARACTER);
    assign w_addrNext  = ROM_ADDR_BITS'(r_char) * ROM_ADDR_BITS'(HEIGHT_PER_CHARACTER)
                       + ROM_ADDR_BITS'(r_row) + ROM_ADDR_BITS'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (reqValid) w_nextState = S_FETCH;
            S_FETCH: w_nextState = S_WAIT;
            S_WAIT:  w_nextState = S_EMIT;
            S_EMIT:  if (rowReady) w_nextState = rowLast ? S_IDLE : S_FETCH;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Underline is applied before blink so that a hidden cell also hides its underline.
    always_comb begin
        w_fgIdx = r_rev ? r_bg : r_fg;
        w_bgIdx = r_rev ? r_fg : r_bg;
        w_bits  = romData;
        if (r_ul && (r_row == ROW_BITS'(HEIGHT_PER_CHARACTER-2)))
            w_bits = '1;
        if (r_blink && blinkPhase)
            w_bits = '0;
        w_idx  = '0;
        w_pixR = '0;
        w_pixG = '0;
        w_pixB = '0;
        for (int c = 0; c < WIDTH_PER_CHARACTER; c++) begin
            w_idx = w_bits[WIDTH_PER_CHARACTER-1-c] ? w_fgIdx : w_bgIdx;
            w_pixR[c*COLOR_CHANNEL_BITS +: COLOR_CHANNEL_BITS] = chanLevel(w_idx[0], w_idx[3]);
            w_pixG[c*COLOR_CHANNEL_BITS +: COLOR_CHANNEL_BITS] = chanLevel(w_idx[1], w_idx[3]);
            w_pixB[c*COLOR_CHANNEL_BITS +: COLOR_CHANNEL_BITS] = chanLevel(w_idx[2], w_idx[3]);
        end
    end

    // The ROM address is loaded on entry to FETCH so the ROM output is ready during WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_char     <= '0;
            r_fg       <= '0;
            r_bg       <= '0;
            r_rev      <= 1'b0;
            r_ul       <= 1'b0;
            r_blink    <= 1'b0;
            r_row      <= '0;
            romAddress <= '0;
            rowValid   <= 1'b0;
            rowIndex   <= '0;
            rowLast    <= 1'b0;
            fontColorR <= '0;
            fontColorG <= '0;
            fontColorB <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (reqValid) begin
                        r_char     <= char;
                        r_fg       <= foregroundColor;
                        r_bg       <= backgroundColor;
                        r_rev      <= attrReverse;
                        r_ul       <= attrUnderline;
                        r_blink    <= attrBlink;
                        r_row      <= '0;
                        romAddress <= w_addrFirst;
                    end
                end
                S_WAIT: begin
                    rowValid   <= 1'b1;
                    rowIndex   <= r_row;
                    rowLast    <= (r_row == ROW_BITS'(HEIGHT_PER_CHARACTER-1));
                    fontColorR <= w_pixR;
                    fontColorG <= w_pixG;
                    fontColorB <= w_pixB;
                end
                S_EMIT: begin
                    if (rowReady) begin
                        rowValid <= 1'b0;
                        if (!rowLast) begin
                            r_row      <= r_row + ROW_BITS'(1);
                            romAddress <= w_addrNext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_font_glyph_renderer.sv
// Scoreboard bench for font_glyph_renderer: a pixel-level reference model predicts every
// row of each requested cell, and a monitor compares whatever the DUT presents.
module tb_font_glyph_renderer;

    localparam int H  = 20;
    localparam int W  = 8;
    localparam int CB = 8;

    typedef struct {
        int          addr;
        int          idx;
        bit          last;
        logic [63:0] r;
        logic [63:0] g;
        logic [63:0] b;
    } rowExp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [7:0]  char = '0;
    logic [3:0]  foregroundColor = '0;
    logic [3:0]  backgroundColor = '0;
    logic        attrReverse = 1'b0;
    logic        attrUnderline = 1'b0;
    logic        attrBlink = 1'b0;
    logic        blinkPhase = 1'b0;
    logic [12:0] romAddress;
    logic [7:0]  romData = '0;
    logic        rowValid;
    logic        rowReady = 1'b0;
    logic [4:0]  rowIndex;
    logic        rowLast;
    logic [63:0] fontColorR;
    logic [63:0] fontColorG;
    logic [63:0] fontColorB;

    logic [7:0]  rom [0:256*H-1];
    rowExp_t     sb[$];
    rowExp_t     monE;
    int          numChecks = 0;
    int          numPassed = 0;
    int          readyMode = 1;
    int          stallCnt = 0;
    bit          expectReady = 1'b0;

    font_glyph_renderer dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady),
        .char(char), .foregroundColor(foregroundColor), .backgroundColor(backgroundColor),
        .attrReverse(attrReverse), .attrUnderline(attrUnderline), .attrBlink(attrBlink),
        .blinkPhase(blinkPhase),
        .romAddress(romAddress), .romData(romData),
        .rowValid(rowValid), .rowReady(rowReady),
        .rowIndex(rowIndex), .rowLast(rowLast),
        .fontColorR(fontColorR), .fontColorG(fontColorG), .fontColorB(fontColorB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) romData <= rom[int'(romAddress)];

    // Mode 0: random back-pressure; 1: always ready; 2: stall five cycles on row 3.
    always begin
        @(posedge clk);
        #1;
        if (readyMode != 2)
            stallCnt = 0;
        if (readyMode == 2 && rowValid && rowIndex == 5'd3 && stallCnt < 5) begin
            rowReady = 1'b0;
            stallCnt++;
        end else if (readyMode == 0) begin
            rowReady = ($urandom_range(0, 3) != 0);
        end else begin
            rowReady = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual === expected)
            numPassed++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    function automatic logic [7:0] level(input logic on, input logic bright);
        if (!on)
            return 8'h00;
        return bright ? 8'hFF : 8'h80;
    endfunction

    task automatic pushCell(input int ch, input int fg, input int bg,
                            input bit rev, input bit ul, input bit blink, input bit phase);
        rowExp_t     e;
        logic [7:0]  bits;
        logic [3:0]  fgE;
        logic [3:0]  bgE;
        logic [3:0]  idx;
        for (int row = 0; row < H; row++) begin
            bits = rom[ch*H + row];
            if (ul && row == H-2) bits = 8'hFF;
            if (blink && phase)   bits = 8'h00;
            fgE = rev ? 4'(bg) : 4'(fg);
            bgE = rev ? 4'(fg) : 4'(bg);
            e.addr = ch*H + row;
            e.idx  = row;
            e.last = (row == H-1);
            e.r = '0; e.g = '0; e.b = '0;
            for (int c = 0; c < W; c++) begin
                idx = bits[7-c] ? fgE : bgE;
                e.r[c*CB +: CB] = level(idx[0], idx[3]);
                e.g[c*CB +: CB] = level(idx[1], idx[3]);
                e.b[c*CB +: CB] = level(idx[2], idx[3]);
            end
            sb.push_back(e);
        end
    endtask

    task automatic applyStimulus(input int ch, input int fg, input int bg,
                                 input bit rev, input bit ul, input bit blink, input bit phase);
        int n = 0;
        blinkPhase = phase;
        @(negedge clk);
        while (!reqReady && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!reqReady) begin
            checkOutput("request ready timeout", 64'(reqReady), 64'd1);
            return;
        end
        char = 8'(ch);
        foregroundColor = 4'(fg);
        backgroundColor = 4'(bg);
        attrReverse = rev;
        attrUnderline = ul;
        attrBlink = blink;
        reqValid = 1'b1;
        pushCell(ch, fg, bg, rev, ul, blink, phase);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("cell drain timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // Compares every presented row against the scoreboard head; pops on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (expectReady) begin
                checkOutput("reqReady after last row", 64'(reqReady), 64'd1);
                expectReady = 1'b0;
            end
            if (rowValid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected row", 64'd1, 64'd0);
                end else begin
                    monE = sb[0];
                    checkOutput("romAddress", 64'(romAddress), 64'(monE.addr));
                    checkOutput("rowIndex", 64'(rowIndex), 64'(monE.idx));
                    checkOutput("rowLast", 64'(rowLast), 64'(monE.last));
                    checkOutput("fontColorR", fontColorR, monE.r);
                    checkOutput("fontColorG", fontColorG, monE.g);
                    checkOutput("fontColorB", fontColorB, monE.b);
                    if (rowReady) begin
                        void'(sb.pop_front());
                        if (monE.last) expectReady = 1'b1;
                    end
                end
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " reqReady"}, 64'(reqReady), 64'd1);
        checkOutput({tag, " rowValid"}, 64'(rowValid), 64'd0);
        checkOutput({tag, " romAddress"}, 64'(romAddress), 64'd0);
        checkOutput({tag, " rowIndex"}, 64'(rowIndex), 64'd0);
        checkOutput({tag, " rowLast"}, 64'(rowLast), 64'd0);
        checkOutput({tag, " colours"}, fontColorR | fontColorG | fontColorB, 64'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256*H; i++) rom[i] = 8'($urandom);
        for (int r = 0; r < H; r++) begin
            rom[16*H + r] = 8'b1000_0001;
            rom[32*H + r] = 8'h00;
            rom[17*H + r] = 8'hFF;
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdleOutputs("reset");

        readyMode = 0;
        applyStimulus(8'h41, 15, 0, 0, 0, 0, 0);
        waitDrain();
        applyStimulus(16, 1, 4, 1, 0, 0, 0);
        waitDrain();
        applyStimulus(32, 10, 0, 0, 1, 0, 0);
        waitDrain();
        applyStimulus(17, 3, 12, 0, 1, 1, 1);
        waitDrain();
        applyStimulus(17, 3, 12, 0, 1, 1, 0);
        waitDrain();

        readyMode = 2;
        applyStimulus(8'h41, 9, 6, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        reqValid = 1'b1;
        char = 8'h55;
        @(negedge clk);
        reqValid = 1'b0;
        waitDrain();

        readyMode = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 15),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            waitDrain();
        end

        readyMode = 1;
        applyStimulus(8'h7E, 7, 8, 0, 0, 0, 0);
        n = 0;
        @(negedge clk);
        while (!(rowValid && rowIndex == 5'd10) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached row 10 before reset", 64'(rowValid && rowIndex == 5'd10), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkIdleOutputs("async reset");
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("post-reset rowValid", 64'(rowValid), 64'd0);
            checkOutput("post-reset reqReady", 64'(reqReady), 64'd1);
        end

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
